// File: rtl/rand_arb_ctrl.sv
// rand_arb_ctrl: shares one LN-type random word generator between NREQ round-robin requesters
// and sequences the generator's reset/seed load. Optional stuck detection: RAND_ARB_STUCK_DET_EN.
//
// state     | meaning
// RESEED_LO | generator held in reset (oGenRST_N=0) with oSeed applied, 2 cycles
// FLUSH     | generator running; its first word is stale and is dropped
// IDLE      | capture strobed words, grant the fresh word to one requester
module rand_arb_ctrl #(
  parameter int            ws            = 16,
  parameter int            NREQ          = 4,
  parameter int            RESEED_N      = 256,
  parameter logic [ws-1:0] SEED_INIT     = 16'hACE1,
  parameter logic [ws-1:0] SEED_FALLBACK = 16'h0001
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic [NREQ-1:0] iReq,
  output logic [NREQ-1:0] oAck,
  output logic [ws-1:0]   oData,
  input  logic [ws-1:0]   iRand,
  input  logic            iRandStrobe,
  input  logic [ws-1:0]   iEntropy,
  output logic            oGenRST_N,
  output logic [ws-1:0]   oSeed,
  output logic            oReseeding
`ifdef RAND_ARB_STUCK_DET_EN
  ,
  output logic            oStuck
`endif
);

  localparam int          PW         = $clog2(NREQ);
  localparam logic [15:0] RESEED_LIM = 16'(RESEED_N);

  typedef enum logic [1:0] {
    RESEED_LO = 2'd0,
    FLUSH     = 2'd1,
    IDLE      = 2'd2
  } state_t;

  state_t          state;
  logic            loCnt;
  logic [ws-1:0]   wordBuf;
  logic            fresh;
  logic [PW-1:0]   ptr;
  logic [15:0]     count;

  logic [NREQ-1:0] reqEff;
  logic            gntVld;
  logic [PW-1:0]   gntIdx;
  logic [PW-1:0]   ptrNext;
  logic [NREQ-1:0] gntOneHot;
  logic [15:0]     cntNext;
  logic            dupHit;
  logic            stuckHit;
  logic            doGrant;
  logic            doReseed;
  logic [ws-1:0]   seedRaw;
  logic [ws-1:0]   seedNext;

  // The bit being acked this cycle still shows its old request; it is not a new one yet.
  always_comb begin
    logic [PW-1:0] idx;
    reqEff = iReq & ~oAck;
    gntVld = 1'b0;
    gntIdx = '0;
    idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (reqEff[idx]) begin
        gntVld = 1'b1;
        gntIdx = idx;
      end
    end
  end

  assign ptrNext   = (int'(gntIdx) == NREQ - 1) ? '0 : gntIdx + PW'(1);
  assign gntOneHot = NREQ'(1) << gntIdx;
  assign cntNext   = (count >= RESEED_LIM) ? count : count + 16'd1;

`ifdef RAND_ARB_STUCK_DET_EN
  logic [1:0] dupCnt;
  logic       lastVld;

  assign dupHit   = (state == IDLE) && fresh && lastVld && (wordBuf == oData);
  assign stuckHit = dupHit && (dupCnt == 2'd3);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dupCnt  <= 2'd0;
      lastVld <= 1'b0;
      oStuck  <= 1'b0;
    end else if ((state == IDLE) && fresh) begin
      if (dupHit) begin
        dupCnt <= stuckHit ? 2'd0 : dupCnt + 2'd1;
        if (stuckHit) oStuck <= 1'b1;
      end else begin
        dupCnt <= 2'd0;
      end
      if (doGrant) lastVld <= 1'b1;
    end
  end
`else
  assign dupHit   = 1'b0;
  assign stuckHit = 1'b0;
`endif

  assign doGrant  = (state == IDLE) && fresh && gntVld && !dupHit;
  assign doReseed = (doGrant && (cntNext == RESEED_LIM)) || stuckHit;
  // On a grant the word leaving now is the last delivered one; otherwise oData already holds it.
  assign seedRaw  = iEntropy ^ (doGrant ? wordBuf : oData);
  assign seedNext = (seedRaw == '0) ? SEED_FALLBACK : seedRaw;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= RESEED_LO;
      loCnt      <= 1'b0;
      wordBuf    <= '0;
      fresh      <= 1'b0;
      ptr        <= '0;
      count      <= '0;
      oAck       <= '0;
      oData      <= '0;
      oGenRST_N  <= 1'b0;
      oSeed      <= SEED_INIT;
      oReseeding <= 1'b1;
    end else begin
      oAck <= '0;
      case (state)
        RESEED_LO: begin
          if (loCnt) begin
            loCnt     <= 1'b0;
            oGenRST_N <= 1'b1;
            state     <= FLUSH;
          end else begin
            loCnt <= 1'b1;
          end
        end
        FLUSH: begin
          if (iRandStrobe) begin
            state      <= IDLE;
            oReseeding <= 1'b0;
          end
        end
        IDLE: begin
          if (iRandStrobe) begin
            wordBuf <= iRand;
            fresh   <= 1'b1;
          end else if (doGrant || dupHit) begin
            fresh <= 1'b0;
          end
          if (doGrant) begin
            oAck  <= gntOneHot;
            oData <= wordBuf;
            ptr   <= ptrNext;
            count <= cntNext;
          end
          if (doReseed) begin
            state      <= RESEED_LO;
            loCnt      <= 1'b0;
            oGenRST_N  <= 1'b0;
            oReseeding <= 1'b1;
            oSeed      <= seedNext;
            count      <= '0;
            fresh      <= 1'b0;
          end
        end
        default: state <= RESEED_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_arb_ctrl.sv
// tb_rand_arb_ctrl: randomized stimulus against a cycle-level reference of the arbitration and
// reseed rules; expected grants go through a queue checked by an independent monitor.
`timescale 1ns/1ps
module tb_rand_arb_ctrl;
  localparam int          WS = 16;
  localparam int          NR = 4;
  localparam int          RN = 4;
  localparam logic [15:0] SI = 16'hACE1;
  localparam logic [15:0] SF = 16'h0001;
`ifdef RAND_ARB_STUCK_DET_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] iReq = '0;
  logic [NR-1:0] oAck;
  logic [WS-1:0] oData;
  logic [WS-1:0] iRand = '0;
  logic          iRandStrobe = 1'b0;
  logic [WS-1:0] iEntropy = '0;
  logic          oGenRST_N;
  logic [WS-1:0] oSeed;
  logic          oReseeding;
`ifdef RAND_ARB_STUCK_DET_EN
  logic          oStuck;
`endif

  always #5 clk = ~clk;

  rand_arb_ctrl #(.ws(WS), .NREQ(NR), .RESEED_N(RN), .SEED_INIT(SI), .SEED_FALLBACK(SF)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iReq(iReq), .oAck(oAck), .oData(oData),
    .iRand(iRand), .iRandStrobe(iRandStrobe), .iEntropy(iEntropy),
    .oGenRST_N(oGenRST_N), .oSeed(oSeed), .oReseeding(oReseeding)
`ifdef RAND_ARB_STUCK_DET_EN
    , .oStuck(oStuck)
`endif
  );

  int nAssert = 0;
  int nFail   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [NR-1:0] ack;
    logic [WS-1:0] data;
  } exp_t;
  exp_t expQ[$];

  // Reference: mode 0 = generator held low, 1 = waiting for stale word, 2 = serving.
  int            mMode = 0, mLowLeft = 2, mPtr = 0, mCount = 0, mDup = 0, w = 0;
  logic [15:0]   mSeed = SI, mBuf = '0, mData = '0, oldBuf = '0, refW = '0;
  bit            mFresh = 0, mLastVld = 0, mStuck = 0, wasFresh = 0, used = 0, reseed = 0;
  logic [NR-1:0] mAck = '0, prevAck = '0, eff = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mMode = 0; mLowLeft = 2; mPtr = 0; mCount = 0; mDup = 0;
      mSeed = SI; mBuf = '0; mData = '0; mFresh = 0; mLastVld = 0; mStuck = 0;
      mAck = '0;
      expQ.delete();
    end else begin
      prevAck = mAck;
      mAck = '0;
      case (mMode)
        0: begin
          mLowLeft--;
          if (mLowLeft == 0) mMode = 1;
        end
        1: if (iRandStrobe) mMode = 2;
        default: begin
          oldBuf = mBuf; wasFresh = mFresh; used = 0; reseed = 0;
          eff = iReq & ~prevAck;
          if (wasFresh && STK && mLastVld && oldBuf == mData) begin
            used = 1;
            mDup++;
            if (mDup == 4) begin
              mStuck = 1; mDup = 0; reseed = 1; refW = mData;
            end
          end else if (wasFresh && eff != 0) begin
            w = -1;
            for (int k = 0; k < NR; k++)
              if (w < 0 && eff[2'((mPtr + k) % NR)]) w = (mPtr + k) % NR;
            mAck[2'(w)] = 1'b1;
            expQ.push_back('{ack: mAck, data: oldBuf});
            mData = oldBuf; mLastVld = 1; mDup = 0; used = 1;
            mPtr = (w + 1) % NR;
            if (mCount < RN) mCount++;
            if (mCount == RN) begin
              reseed = 1; refW = oldBuf;
            end
          end else if (wasFresh) begin
            mDup = 0;
          end
          if (iRandStrobe) begin
            mBuf = iRand; mFresh = 1;
          end else if (used) begin
            mFresh = 0;
          end
          if (reseed) begin
            mMode = 0; mLowLeft = 2; mCount = 0; mFresh = 0;
            mSeed = ((iEntropy ^ refW) == 16'h0) ? SF : (iEntropy ^ refW);
          end
        end
      endcase
    end
  end

  // Monitor: pops an expected grant whenever one is due and checks status outputs every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        chk("ack", 32'(oAck), 32'(e.ack));
        chk("ack_data", 32'(oData), 32'(e.data));
      end else begin
        chk("no_ack", 32'(oAck), 32'(0));
      end
      chk("data_hold", 32'(oData), 32'(mData));
      chk("gen_rst_n", 32'(oGenRST_N), 32'(mMode != 0));
      chk("seed", 32'(oSeed), 32'(mSeed));
      chk("reseeding", 32'(oReseeding), 32'(mMode != 2));
`ifdef RAND_ARB_STUCK_DET_EN
      chk("stuck", 32'(oStuck), 32'(mStuck));
`endif
    end
  end

  // Stimulus controls
  int            cyc = 0, stbMode = 0, reqMode = 0;
  bit            randFix = 0, entFix = 0;
  logic [15:0]   randConst = '0, entConst = '0;
  logic [NR-1:0] reqFix = '0, reqs = '0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (stbMode)
      0:       iRandStrobe = ((cyc % 2) == 0);
      1:       iRandStrobe = 1'b1;
      default: iRandStrobe = 1'($urandom_range(0, 1));
    endcase
    iRand    = randFix ? randConst : 16'($urandom);
    iEntropy = entFix ? entConst : 16'($urandom);
    if (reqMode == 0) begin
      iReq = reqFix;
    end else begin
      for (int b = 0; b < NR; b++) begin
        if (oAck[b]) reqs[b] = ($urandom_range(0, 3) == 0);
        else if (!reqs[b]) reqs[b] = ($urandom_range(0, 2) == 0);
      end
      iReq = reqs;
    end
  endtask

  task automatic reset_checks();
    chk("rst_ack", 32'(oAck), 32'(0));
    chk("rst_data", 32'(oData), 32'(0));
    chk("rst_gen_rst_n", 32'(oGenRST_N), 32'(0));
    chk("rst_seed", 32'(oSeed), 32'(SI));
    chk("rst_reseeding", 32'(oReseeding), 32'(1));
`ifdef RAND_ARB_STUCK_DET_EN
    chk("rst_stuck", 32'(oStuck), 32'(0));
`endif
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Post-reset sequence with strobes every 2 cycles, no requests
    stbMode = 0; reqMode = 0; reqFix = 4'b0000;
    repeat (12) step();

    // All four requesting: rotating grants
    reqFix = 4'b1111;
    repeat (40) step();

    // Single requester, forces wrap-around of the pointer
    reqFix = 4'b0100;
    repeat (20) step();
    reqFix = 4'b1011;
    repeat (20) step();

    // Random requesters, random strobes
    reqMode = 1; stbMode = 2;
    repeat (400) step();

    // Entropy equal to every delivered word: computed seed is 0, fallback expected
    reqMode = 0; reqFix = 4'b1111; stbMode = 0;
    randFix = 1; randConst = 16'h1234; entFix = 1; entConst = 16'h1234;
    repeat (30) step();
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (!oGenRST_N) seen = 1;
    end
    chk("reseed_seen", 32'(seen), 32'(1));
    if (seen) chk("fallback_seed", 32'(oSeed), 32'(SF));
    randFix = 0; entFix = 0;

    // Reset in the middle of back-to-back grants
    stbMode = 1;
    repeat (9) step();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    // Strobe every cycle: coincident strobes and grants
    reqMode = 1;
    repeat (150) step();

`ifdef RAND_ARB_STUCK_DET_EN
    // Constant generator output: one delivery, then discards until stuck
    reqMode = 0; reqFix = 4'b1111; stbMode = 0;
    randFix = 1; randConst = 16'h5A5A;
    repeat (40) step();
    @(negedge clk);
    chk("stuck_set", 32'(oStuck), 32'(1));
    randFix = 0;
    repeat (30) step();
    @(negedge clk);
    chk("stuck_sticky", 32'(oStuck), 32'(1));
`endif

    reqMode = 0; reqFix = 4'b0000;
    repeat (3) step();
    @(negedge clk);
    #1;
    chk("queue_drain", 32'(expQ.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/rand_arb_ctrl.md
Name: rand_arb_ctrl

Overview:
Shares one pseudo-random word generator (LN-type, ws-bit) between NREQ requesters using round-robin arbitration. Each generated word is delivered to at most one requester. The block also sequences the generator: it holds it in reset, loads its seed, and periodically reseeds it from an entropy word supplied by the ADC/clock-jitter sampler. It sits between the generator/entropy sources and the consumer blocks.

Parameters:
ws, 16, word width of random/seed/entropy data
NREQ, 4, number of requesters (2..8)
RESEED_N, 256, words delivered between reseeds (1..65535)
SEED_INIT, 16'hACE1, seed loaded after iRST_N release
SEED_FALLBACK, 16'h0001, seed used when the computed seed is 0

Ports:
iCLK  in  1  system clock; all logic on posedge
iRST_N  in  1  reset, asynchronous, active-low
iReq  in  NREQ  per-requester request level; held until acked
oAck  out  NREQ  one-cycle grant pulse, at most one bit set
oData  out  ws  word delivered; valid in the oAck cycle, held afterwards
iRand  in  ws  generator output word
iRandStrobe  in  1  one-cycle pulse: iRand holds a new word
iEntropy  in  ws  entropy word from the sampler; sampled at reseed
oGenRST_N  out  1  active-low reset/seed-load to the generator
oSeed  out  ws  seed to the generator; stable while oGenRST_N=0
oReseeding  out  1  high in RESEED_LO and FLUSH

Behaviour:
- Reset values: oAck=0, oData=0, oGenRST_N=0, oSeed=SEED_INIT, oReseeding=1, rr pointer=0, delivered count=0, word buffer empty. FSM state=RESEED_LO, low-counter=0.
- Word buffer: on iRandStrobe in IDLE, capture iRand and set fresh=1. A second strobe before delivery overwrites the buffer. Strobes in RESEED_LO are ignored.
- IDLE:
  - If fresh=1 and iReq!=0: grant the first set iReq bit at or after the pointer, wrapping modulo NREQ.
  - Next cycle: oAck[i]=1 and oData=buffer. In the same edge, clear fresh, set pointer=(i+1) mod NREQ and increment count.
  - Grant latency: 1 cycle from the edge where both fresh and iReq are seen.
- Strobe arriving in the grant cycle: the new word is captured and fresh stays 1. The next word is never lost or double-delivered.
- Requester re-request: an iReq bit still high the cycle after its oAck is a new request. It is served only when a new word is fresh.
- Reseed trigger: when count reaches RESEED_N after a grant, go to RESEED_LO.
  - Seed = iEntropy XOR last delivered word; if the result is 0, use SEED_FALLBACK.
  - Latch the seed into oSeed on entry. count=0, fresh=0.
- RESEED_LO: oGenRST_N=0 for exactly 2 cycles, then go to FLUSH with oGenRST_N=1.
- FLUSH: discard the first iRandStrobe word (stale generator output register), then go to IDLE. oReseeding=0 from the IDLE entry.
- Post-reset sequence: RESEED_LO (seed SEED_INIT) -> FLUSH -> IDLE, identical to a normal reseed.
- No grants during RESEED_LO/FLUSH; requests stay pending.
- Reset mid-operation: all state returns to reset values immediately. A pending ack is dropped and not replayed.
- count is 16 bits and saturates at RESEED_N; it never wraps.

Optional Feature:
RAND_ARB_STUCK_DET_EN
- Defined:
  - A fresh word equal to the last delivered word is discarded (not granted) and increments a duplicate counter.
  - 4 consecutive duplicates assert sticky output oStuck (1 bit, reset 0, cleared only by iRST_N) and force an immediate reseed, irrespective of count.
  - A non-duplicate word clears the duplicate counter.
- Undefined: oStuck port absent; duplicates are delivered normally.

Test Plan:
- Reset release, iRand strobed every 2 cycles -> oGenRST_N low 2 cycles with oSeed=16'hACE1. First strobe after that is discarded. oReseeding falls on IDLE entry.
- iReq=4'b1111 held, 8 fresh words -> oAck order 0001,0010,0100,1000,0001,... Each oData equals the captured iRand; no word delivered twice.
- iReq=4'b0100 only, pointer=3 -> grant wraps to bit 2; pointer becomes 3.
- RESEED_N=4, iEntropy=16'h1234, 4th delivered word 16'h1234 -> seed 0 replaced by oSeed=16'h0001. Requests stall through RESEED_LO/FLUSH.
- Strobe in the same cycle as a grant -> next requester receives the new word one grant later; no loss.
- With RAND_ARB_STUCK_DET_EN, iRand constant 16'h5A5A -> one delivery, then 4 discards. oStuck=1 and a reseed starts; oStuck stays 1 until iRST_N.
